// File: rtl/s_wb_sequencer.sv
// s_wb_sequencer: single write-port sequencer for the S register file.
// Arbitrates four result sources, buffers losers in hold regs, tracks reservations.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   i_rsv_en/i_rsv_addr issue-side destination reservation
//   i_res_vld/addr/data per-source result pulses (packed by source index)
//   o_wr_en/addr/data   register file write port (combinational grant)
//   o_busy              per-register reservation bits
//   o_hold              per-source hold occupancy
//   o_err               sticky: [0] hold overflow, [1] busy reserve, [2] unreserved write
module s_wb_sequencer #(
  parameter int WIDTH    = 64,
  parameter int DEPTH    = 8,
  parameter int LOGDEPTH = 3,
  parameter int NSRC     = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_rsv_en,
  input  logic [LOGDEPTH-1:0]      i_rsv_addr,
  input  logic [NSRC-1:0]          i_res_vld,
  input  logic [NSRC*LOGDEPTH-1:0] i_res_addr,
  input  logic [NSRC*WIDTH-1:0]    i_res_data,
  output logic                     o_wr_en,
  output logic [LOGDEPTH-1:0]      o_wr_addr,
  output logic [WIDTH-1:0]         o_wr_data,
  output logic [DEPTH-1:0]         o_busy,
  output logic [NSRC-1:0]          o_hold,
  output logic [2:0]               o_err
);

  logic [NSRC-1:0]                hold_vld_q, hold_vld_d;
  logic [NSRC-1:0][LOGDEPTH-1:0]  hold_addr_q, hold_addr_d;
  logic [NSRC-1:0][WIDTH-1:0]     hold_data_q, hold_data_d;
  logic [DEPTH-1:0]               busy_q, busy_d;
  logic [2:0]                     err_q, err_d;

  logic [NSRC-1:0]     cand;
  logic [NSRC-1:0]     gnt;
  logic                found;
  logic                wr_en;
  logic [LOGDEPTH-1:0] wr_addr;
  logic [WIDTH-1:0]    wr_data;
  logic                ovf;

  // Fixed-priority grant; a held entry is older than a fresh one on its source.
  always_comb begin
    cand    = hold_vld_q | i_res_vld;
    gnt     = '0;
    found   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    for (int s = 0; s < NSRC; s++) begin
      if (cand[s] && !found) begin
        found  = 1'b1;
        gnt[s] = 1'b1;
        if (hold_vld_q[s]) begin
          wr_addr = hold_addr_q[s];
          wr_data = hold_data_q[s];
        end else begin
          wr_addr = i_res_addr[s*LOGDEPTH +: LOGDEPTH];
          wr_data = i_res_data[s*WIDTH +: WIDTH];
        end
      end
    end
    wr_en = found & ~rst;
  end

  // Hold registers: free on grant (refilled by a same-cycle arrival),
  // capture ungranted arrivals, flag overflow when already occupied.
  always_comb begin
    hold_vld_d  = hold_vld_q;
    hold_addr_d = hold_addr_q;
    hold_data_d = hold_data_q;
    ovf         = 1'b0;
    for (int s = 0; s < NSRC; s++) begin
      if (gnt[s]) begin
        if (hold_vld_q[s]) begin
          hold_vld_d[s]  = i_res_vld[s];
          hold_addr_d[s] = i_res_addr[s*LOGDEPTH +: LOGDEPTH];
          hold_data_d[s] = i_res_data[s*WIDTH +: WIDTH];
        end
      end else if (i_res_vld[s]) begin
        if (hold_vld_q[s]) begin
          ovf = 1'b1;
        end else begin
          hold_vld_d[s]  = 1'b1;
          hold_addr_d[s] = i_res_addr[s*LOGDEPTH +: LOGDEPTH];
          hold_data_d[s] = i_res_data[s*WIDTH +: WIDTH];
        end
      end
    end
  end

  // Reservations: a same-cycle set overrides the write's clear (new owner).
  always_comb begin
    busy_d = busy_q;
    err_d  = err_q;
    if (wr_en) busy_d[wr_addr] = 1'b0;
    if (i_rsv_en) busy_d[i_rsv_addr] = 1'b1;
    if (ovf) err_d[0] = 1'b1;
    if (i_rsv_en && busy_q[i_rsv_addr] &&
        !(wr_en && (wr_addr == i_rsv_addr)))
      err_d[1] = 1'b1;
    if (wr_en && !busy_q[wr_addr]) err_d[2] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_vld_q <= '0;
      busy_q     <= '0;
      err_q      <= '0;
    end else begin
      hold_vld_q <= hold_vld_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
    end
  end

  // Payload only matters while its valid bit is set.
  always_ff @(posedge clk) begin
    hold_addr_q <= hold_addr_d;
    hold_data_q <= hold_data_d;
  end

  assign o_wr_en   = wr_en;
  assign o_wr_addr = wr_addr;
  assign o_wr_data = wr_data;
  assign o_busy    = busy_q;
  assign o_hold    = hold_vld_q;
  assign o_err     = err_q;

endmodule

// File: tb/tb_s_wb_sequencer.sv
// tb_s_wb_sequencer: table-driven bench with a write scoreboard.
// Rows drive one cycle; registered state is checked before each edge.
module tb_s_wb_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_rsv_en;
  logic [2:0]  i_rsv_addr;
  logic [3:0]  i_res_vld;
  logic [11:0] i_res_addr;
  logic [255:0] i_res_data;
  logic        o_wr_en;
  logic [2:0]  o_wr_addr;
  logic [63:0] o_wr_data;
  logic [7:0]  o_busy;
  logic [3:0]  o_hold;
  logic [2:0]  o_err;

  always #5 clk = ~clk;

  s_wb_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .i_rsv_en   (i_rsv_en),
    .i_rsv_addr (i_rsv_addr),
    .i_res_vld  (i_res_vld),
    .i_res_addr (i_res_addr),
    .i_res_data (i_res_data),
    .o_wr_en    (o_wr_en),
    .o_wr_addr  (o_wr_addr),
    .o_wr_data  (o_wr_data),
    .o_busy     (o_busy),
    .o_hold     (o_hold),
    .o_err      (o_err)
  );

  typedef struct {
    logic        rst;
    logic        re;
    logic [2:0]  ra;
    logic [3:0]  vld;
    logic [11:0] adr;
    logic [63:0] base;
    logic        en;
    logic [2:0]  wa;
    logic [63:0] wd;
    logic [7:0]  busy;
    logic [3:0]  hold;
    logic [2:0]  err;
  } vec_t;

  typedef struct {
    logic [2:0]  a;
    logic [63:0] d;
  } wr_t;

  vec_t vec[$];
  wr_t  sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic add(logic r, logic re, logic [2:0] ra,
                     logic [3:0] vld, logic [11:0] adr, logic [63:0] base,
                     logic en, logic [2:0] wa, logic [63:0] wd,
                     logic [7:0] busy, logic [3:0] hold, logic [2:0] err);
    vec_t v;
    v.rst = r; v.re = re; v.ra = ra;
    v.vld = vld; v.adr = adr; v.base = base;
    v.en = en; v.wa = wa; v.wd = wd;
    v.busy = busy; v.hold = hold; v.err = err;
    vec.push_back(v);
  endtask

  // Source s carries base + s.
  task automatic drive(logic r, logic re, logic [2:0] ra,
                       logic [3:0] vld, logic [11:0] adr, logic [63:0] base);
    rst        = r;
    i_rsv_en   = re;
    i_rsv_addr = ra;
    i_res_vld  = vld;
    i_res_addr = adr;
    for (int s = 0; s < 4; s++)
      i_res_data[s*64 +: 64] = base + 64'(s);
  endtask

  task automatic check_wr(string tag);
    wr_t w;
    if (o_wr_en === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL %s unexpected write: addr %0d data %0h",
                 tag, o_wr_addr, o_wr_data);
      end else begin
        w = sb.pop_front();
        chk({tag, " wr_addr"}, 64'(o_wr_addr), 64'(w.a));
        chk({tag, " wr_data"}, o_wr_data, w.d);
      end
    end
  endtask

  localparam logic [63:0] A = 64'h0123_4567_89AB_CDEE;
  localparam logic [63:0] B = 64'hB0B0_0000_0000_0000;
  localparam logic [63:0] C = 64'hC0C0_0000_0000_0000;
  localparam logic [63:0] D = 64'hD0D0_0000_0000_0000;
  localparam logic [63:0] E = 64'hE0E0_0000_0000_0000;
  localparam logic [63:0] F = 64'hF0F0_0000_0000_0000;
  localparam logic [63:0] G = 64'h6060_0000_0000_0000;
  localparam logic [63:0] H = 64'h7070_0000_0000_0000;
  localparam logic [63:0] I = 64'h8080_0000_0000_0000;
  localparam logic [63:0] J = 64'h9090_0000_0000_0000;
  localparam logic [63:0] K = 64'h5A5A_0000_0000_0000;
  localparam logic [63:0] M = 64'h6B6B_0000_0000_0000;

  initial begin
    drive(1'b1, 1'b0, 3'd0, 4'd0, 12'd0, 64'd0);
    repeat (2) @(negedge clk);

    // rst re ra vld adr base | en wa wd | busy hold err
    add(0,0,0,4'b0000,12'd0,0, 0,0,0, 8'h00,4'h0,3'd0);
    add(0,1,3,4'b0000,12'd0,0, 0,0,0, 8'h00,4'h0,3'd0);
    add(0,0,0,4'b0010,{3'd0,3'd0,3'd3,3'd0},A,
        1,3,64'h0123_4567_89AB_CDEF, 8'h08,4'h0,3'd0);
    add(0,1,1,4'b0000,12'd0,0, 0,0,0, 8'h00,4'h0,3'd0);
    add(0,1,2,4'b0000,12'd0,0, 0,0,0, 8'h02,4'h0,3'd0);
    add(0,1,5,4'b0000,12'd0,0, 0,0,0, 8'h06,4'h0,3'd0);
    add(0,1,6,4'b0000,12'd0,0, 0,0,0, 8'h26,4'h0,3'd0);
    add(0,0,0,4'b1111,{3'd6,3'd5,3'd2,3'd1},B,
        1,1,B, 8'h66,4'h0,3'd0);
    add(0,0,0,4'b0000,12'd0,0, 1,2,B+1, 8'h64,4'hE,3'd0);
    add(0,0,0,4'b0000,12'd0,0, 1,5,B+2, 8'h60,4'hC,3'd0);
    add(0,0,0,4'b0000,12'd0,0, 1,6,B+3, 8'h40,4'h8,3'd0);
    add(0,0,0,4'b0000,12'd0,0, 0,0,0, 8'h00,4'h0,3'd0);
    add(0,1,4,4'b0000,12'd0,0, 0,0,0, 8'h00,4'h0,3'd0);
    add(0,1,7,4'b0000,12'd0,0, 0,0,0, 8'h10,4'h0,3'd0);
    add(0,1,4,4'b0101,{3'd0,3'd7,3'd0,3'd4},C,
        1,4,C, 8'h90,4'h0,3'd0);
    add(0,0,0,4'b0001,{3'd0,3'd0,3'd0,3'd4},D,
        1,4,D, 8'h90,4'h4,3'd0);
    add(0,0,0,4'b0000,12'd0,0, 1,7,C+2, 8'h80,4'h4,3'd0);
    add(0,1,1,4'b0000,12'd0,0, 0,0,0, 8'h00,4'h0,3'd0);
    add(0,1,2,4'b0000,12'd0,0, 0,0,0, 8'h02,4'h0,3'd0);
    add(0,1,3,4'b0000,12'd0,0, 0,0,0, 8'h06,4'h0,3'd0);
    add(0,1,5,4'b0101,{3'd0,3'd5,3'd0,3'd1},E,
        1,1,E, 8'h0E,4'h0,3'd0);
    add(0,0,0,4'b0101,{3'd0,3'd6,3'd0,3'd2},F,
        1,2,F, 8'h2C,4'h4,3'd0);
    add(0,0,0,4'b0001,{3'd0,3'd0,3'd0,3'd3},G,
        1,3,G, 8'h28,4'h4,3'd1);
    add(0,0,0,4'b0000,12'd0,0, 1,5,E+2, 8'h20,4'h4,3'd1);
    add(0,0,0,4'b0000,12'd0,0, 0,0,0, 8'h00,4'h0,3'd1);
    add(1,0,0,4'b0000,12'd0,0, 0,0,0, 8'h00,4'h0,3'd1);
    add(0,1,2,4'b0000,12'd0,0, 0,0,0, 8'h00,4'h0,3'd0);
    add(0,1,2,4'b0010,{3'd0,3'd0,3'd2,3'd0},H,
        1,2,H+1, 8'h04,4'h0,3'd0);
    add(0,1,2,4'b0000,12'd0,0, 0,0,0, 8'h04,4'h0,3'd0);
    add(0,0,0,4'b0000,12'd0,0, 0,0,0, 8'h04,4'h0,3'd2);
    add(0,0,0,4'b1000,12'd0,I, 1,0,I+3, 8'h04,4'h0,3'd2);
    add(0,0,0,4'b0000,12'd0,0, 0,0,0, 8'h04,4'h0,3'd6);
    add(0,0,0,4'b1111,{3'd3,3'd2,3'd1,3'd0},J,
        1,0,J, 8'h04,4'h0,3'd6);
    add(1,0,0,4'b0001,12'd0,J, 0,0,0, 8'h04,4'hE,3'd6);
    add(0,0,0,4'b0000,12'd0,0, 0,0,0, 8'h00,4'h0,3'd0);
    add(0,0,0,4'b0000,12'd0,0, 0,0,0, 8'h00,4'h0,3'd0);

    foreach (vec[i]) begin
      drive(vec[i].rst, vec[i].re, vec[i].ra,
            vec[i].vld, vec[i].adr, vec[i].base);
      if (vec[i].en) sb.push_back('{vec[i].wa, vec[i].wd});
      #2;
      chk($sformatf("r%0d wr_en", i), 64'(o_wr_en), 64'(vec[i].en));
      check_wr($sformatf("r%0d", i));
      chk($sformatf("r%0d busy", i), 64'(o_busy), 64'(vec[i].busy));
      chk($sformatf("r%0d hold", i), 64'(o_hold), 64'(vec[i].hold));
      chk($sformatf("r%0d err", i), 64'(o_err), 64'(vec[i].err));
      @(negedge clk);
    end

    // Granted held entry refilled by a same-cycle arrival on its source.
    drive(1'b0, 1'b0, 3'd0, 4'b0011, {3'd0,3'd0,3'd2,3'd1}, K);
    sb.push_back('{3'd1, K});
    #2;
    check_wr("refill c1");
    chk("refill c1 hold", 64'(o_hold), 64'h0);
    @(negedge clk);
    drive(1'b0, 1'b0, 3'd0, 4'b0010, {3'd0,3'd0,3'd3,3'd0}, M);
    sb.push_back('{3'd2, K + 64'd1});
    #2;
    chk("refill c2 wr_en", 64'(o_wr_en), 64'h1);
    check_wr("refill c2");
    chk("refill c2 hold", 64'(o_hold), 64'h2);
    @(negedge clk);
    drive(1'b0, 1'b0, 3'd0, 4'b0000, 12'd0, 64'd0);
    sb.push_back('{3'd3, M + 64'd1});
    #2;
    chk("refill c3 wr_en", 64'(o_wr_en), 64'h1);
    check_wr("refill c3");
    chk("refill c3 hold", 64'(o_hold), 64'h2);
    @(negedge clk);
    #2;
    chk("refill c4 wr_en", 64'(o_wr_en), 64'h0);
    chk("refill c4 hold", 64'(o_hold), 64'h0);
    chk("sb drained", 64'(sb.size()), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
